ct_l2cache_data_banked_array: RTL
=================================

// Module: ct_l2cache_data_banked_array
// PURPOSE
//  Banked, pipelined L2 data store. Splits one request stream across BANK_NUM single-port SRAM banks.
//  Each bank runs a multi-cycle access of ACC_CYC cycles. Read data returns in order at fixed latency.
//  Sits between the L2 data pipeline and the ct_spsram_* macros.
// PARAMETERS
//  DATA_W   128  data width per access; multiple of 8
//  IDX_W    13   full index width, bank bits included
//  BANK_NUM 4    bank count; power of 2 in 1..8; bank select = req_idx[BSEL_W-1:0]
//  ACC_CYC  2    SRAM cycles per access, 1..4
// PORTS
//  forever_cpuclk      in   1         clock
//  cpurst_b            in   1         async reset, active-low
//  pad_yy_icg_scan_en  in   1         scan enable, forwarded to macros
//  req_vld             in   1         request valid
//  req_rdy             out  1         request ready
//  req_wr              in   1         1 = write, 0 = read
//  req_idx             in   IDX_W     row index; low BSEL_W bits select the bank
//  req_wdata           in   DATA_W    write data
//  req_wbe             in   DATA_W/8  byte enables, active-high
//  rd_vld              out  1         read data valid, one-cycle pulse
//  rd_data             out  DATA_W    read data
//  bank_busy           out  BANK_NUM  per-bank busy vector
// BEHAVIOUR
//  - Clock, reset: single clock forever_cpuclk; cpurst_b is asynchronous, active-low.
//  - Reset values: bank_busy = 0, rd_vld = 0, rd_data = 0, return pipeline empty, req_rdy = 1.
//  - Ready: req_rdy = ~bank_busy[bank_sel]. Combinational from state and req_idx only; never from req_vld.
//  - Accept: req_vld & req_rdy in cycle T.
//    - The selected bank's macro gets CEN = 0 in cycle T.
//    - A = req_idx[IDX_W-1:BSEL_W].
//    - GWEN = ~req_wr.
//    - WEN = ~(each req_wbe bit replicated 8x).
//  - Busy window: bank_busy[b] is high in cycles T+1 .. T+ACC_CYC-1. Driven by a per-bank down-counter.
//    - ACC_CYC = 1: the same bank accepts back-to-back.
//    - Different banks accept one request every cycle regardless of ACC_CYC.
//  - Write, no bytes enabled (req_wr = 1, req_wbe = 0): accepted as a no-op. CEN stays high, no busy, no rd_vld.
//  - Read return
//    - A shift register of depth ACC_CYC carries {valid, bank_id}.
//    - At stage ACC_CYC the bank Q is muxed and flopped into rd_data.
//    - rd_vld is high in cycle T+ACC_CYC+1.
//    - Fixed latency gives in-order returns with at most one return per cycle; no arbitration.
//  - rd_data holds its last value while rd_vld = 0. Writes never pulse rd_vld.
//  - Read following a write to the same row: the read is accepted only after the write's busy window.
//    It returns the new data; no forwarding path.
//  - Reset mid-operation
//    - The pipeline clears and in-flight reads never return.
//    - SRAM contents of a write in flight are undefined.
//    - Counters restart at 0.
//  - Widths: BSEL_W = $clog2(BANK_NUM), with BANK_NUM = 1 giving BSEL_W = 0 and no select bits.
//    Row width = IDX_W - BSEL_W.
// CONFIGURATION
//  - L2C_DATA_OUT_FLOP_EN defined
//    - Adds a second output register stage, reset to 0, for timing closure.
//    - rd_vld moves to T+ACC_CYC+2.
//    - Accept and busy timing are unchanged.
//  - L2C_DATA_OUT_FLOP_EN undefined: latency is ACC_CYC+1, as above.
// STRUCTURE
//  - Package ct_l2cache_data_pkg:
//    - BSEL_W function.
//    - Return-pipe entry typedef {vld, bank_id[BSEL_W-1:0]}.
//    - Byte-to-bit WEN expansion function.
//  - Sub-module ct_l2cache_data_bank, generated BANK_NUM times:
//    - Holds the busy down-counter, CEN/GWEN/WEN/A drive and the ct_spsram_* macro for depth 2^(IDX_W-BSEL_W).
//    - Outputs busy and Q.
//  - Top level: bank decode, req_rdy, return shift register, output mux and flops.
// TESTING
//  1. Reset: cpurst_b low mid-stream, then released.
//     -> rd_vld = 0, rd_data = 0, bank_busy = 0, req_rdy = 1, no stale return after release.
//  2. ACC_CYC = 2, BANK_NUM = 4. Write idx 0x004 data 0xA5.. full wbe, then read idx 0x004 the next cycle.
//     -> Read stalls 1 cycle (req_rdy = 0). rd_vld at accept+3 with data 0xA5...
//  3. Reads to idx 0x000, 0x001, 0x002, 0x003 on consecutive cycles.
//     -> All accepted back-to-back; four consecutive rd_vld pulses in issue order.
//  4. Write wbe = 0x0001 of 0xFF.. over 0x00.., then read.
//     -> Only byte 0 = 0xFF, rest 0x00. Also: write with wbe = 0 is accepted, no busy, contents unchanged.
//  5. Read accepted, then cpurst_b asserted 1 cycle later.
//     -> That read never produces rd_vld.
//  6. L2C_DATA_OUT_FLOP_EN defined, ACC_CYC = 1, read issued every cycle to one bank.
//     -> Full throughput; rd_vld latency = 3.

Source files
------------

// File: rtl/ct_l2cache_data_pkg.sv
// Shared types and helpers for the banked L2 data array: bank-select width,
// return-pipe entry layout and byte-to-bit write-enable expansion.
package ct_l2cache_data_pkg;

  // Wide enough for the largest supported bank count (8).
  localparam int BANK_ID_W = 3;

  function automatic int bsel_w(input int bank_num);
    return (bank_num <= 1) ? 0 : $clog2(bank_num);
  endfunction

  typedef struct packed {
    logic                 vld;
    logic [BANK_ID_W-1:0] bank_id;
  } ret_entry_t;

  // Macro WEN is active-low per bit; an enabled byte clears its eight bits.
  function automatic logic [7:0] wen_byte(input logic be);
    return {8{~be}};
  endfunction

endpackage

// File: rtl/ct_l2cache_data_bank.sv
// One L2 data bank: busy down-counter, active-low macro controls and a
// behavioural single-port SRAM standing in for the ct_spsram macro.
module ct_l2cache_data_bank
  import ct_l2cache_data_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int ROW_W   = 11,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              sel,
  input  logic              wr,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic              busy,
  output logic [DATA_W-1:0] q
);

  logic              cen;
  logic              gwen;
  logic [DATA_W-1:0] wen;
  logic [ROW_W-1:0]  addr;
  logic [1:0]        busy_cnt;
  logic [DATA_W-1:0] q_p1;
  logic [DATA_W-1:0] mem [2**ROW_W];
  logic              unused_scan_en;

  // A write with no bytes enabled never touches the macro.
  assign cen  = ~(sel & (~wr | (|wbe)));
  assign gwen = ~wr;
  assign addr = row;

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_wen
    assign wen[8*i +: 8] = wen_byte(wbe[i]);
  end

  // The behavioural macro has no scan chain.
  assign unused_scan_en = scan_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (!cen) begin
      busy_cnt <= 2'(ACC_CYC - 1);
    end else if (busy_cnt != 2'd0) begin
      busy_cnt <= busy_cnt - 2'd1;
    end
  end

  assign busy = |busy_cnt;

  // SRAM array stage: Q only changes on reads and holds through the busy window.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!gwen) begin
        mem[addr] <= (mem[addr] & wen) | (wdata & ~wen);
      end else begin
        q_p1 <= mem[addr];
      end
    end
  end

  assign q = q_p1;

endmodule

// File: rtl/ct_l2cache_data_banked_array.sv
// Banked, pipelined L2 data store with fixed-latency in-order read return.
// Define L2C_DATA_OUT_FLOP_EN to add a second output register stage.
module ct_l2cache_data_banked_array
  import ct_l2cache_data_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int IDX_W    = 13,
  parameter int BANK_NUM = 4,
  parameter int ACC_CYC  = 2
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                pad_yy_icg_scan_en,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                req_wr,
  input  logic [IDX_W-1:0]    req_idx,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wbe,
  output logic                rd_vld,
  output logic [DATA_W-1:0]   rd_data,
  output logic [BANK_NUM-1:0] bank_busy
);

  localparam int BSEL_W = bsel_w(BANK_NUM);
  localparam int ROW_W  = IDX_W - BSEL_W;

  logic [BANK_ID_W-1:0] bank_sel;
  logic [BANK_NUM-1:0]  bank_hit;
  logic [ROW_W-1:0]     req_row;
  logic                 req_acc;
  logic [DATA_W-1:0]    bank_q [BANK_NUM];
  logic [DATA_W-1:0]    ret_q;
  ret_entry_t           ret_new;
  ret_entry_t           ret_p [ACC_CYC];
  logic                 rd_vld_p1;
  logic [DATA_W-1:0]    rd_data_p1;

  if (BSEL_W == 0) begin : g_one_bank
    assign bank_sel = '0;
  end else begin : g_multi_bank
    assign bank_sel = BANK_ID_W'(req_idx[BSEL_W-1:0]);
  end

  always_comb begin
    bank_hit = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_hit[b] = (bank_sel == BANK_ID_W'(b));
    end
  end

  assign req_rdy = ~|(bank_busy & bank_hit);
  assign req_acc = req_vld & req_rdy;
  assign req_row = req_idx[IDX_W-1:BSEL_W];

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    ct_l2cache_data_bank #(
      .DATA_W  (DATA_W),
      .ROW_W   (ROW_W),
      .ACC_CYC (ACC_CYC)
    ) u_bank (
      .clk     (forever_cpuclk),
      .rst_n   (cpurst_b),
      .scan_en (pad_yy_icg_scan_en),
      .sel     (req_acc & bank_hit[b]),
      .wr      (req_wr),
      .row     (req_row),
      .wdata   (req_wdata),
      .wbe     (req_wbe),
      .busy    (bank_busy[b]),
      .q       (bank_q[b])
    );
  end

  assign ret_new.vld     = req_acc & ~req_wr;
  assign ret_new.bank_id = bank_sel;

  // Return pipe stages 1..ACC_CYC track which bank owes read data.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < ACC_CYC; i++) begin
        ret_p[i] <= '0;
      end
    end else begin
      ret_p[0] <= ret_new;
      for (int i = 1; i < ACC_CYC; i++) begin
        ret_p[i] <= ret_p[i-1];
      end
    end
  end

  always_comb begin
    ret_q = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (ret_p[ACC_CYC-1].bank_id == BANK_ID_W'(b)) begin
        ret_q = bank_q[b];
      end
    end
  end

  // First output stage: capture the owing bank's Q at stage ACC_CYC.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      rd_vld_p1 <= ret_p[ACC_CYC-1].vld;
      if (ret_p[ACC_CYC-1].vld) begin
        rd_data_p1 <= ret_q;
      end
    end
  end

`ifdef L2C_DATA_OUT_FLOP_EN
  logic              rd_vld_p2;
  logic [DATA_W-1:0] rd_data_p2;

  // Second output stage for timing closure.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_p2  <= 1'b0;
      rd_data_p2 <= '0;
    end else begin
      rd_vld_p2 <= rd_vld_p1;
      if (rd_vld_p1) begin
        rd_data_p2 <= rd_data_p1;
      end
    end
  end

  assign rd_vld  = rd_vld_p2;
  assign rd_data = rd_data_p2;
`else
  assign rd_vld  = rd_vld_p1;
  assign rd_data = rd_data_p1;
`endif

endmodule
